// File: rtl/ram_access_arbiter.sv
// Arbitrates the shared single-port RAM between UART rx (write), processor (r/w)
// and UART tx (read); mode-gated eligibility, 4-state req/ack FSM on falling edges.
module ram_access_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              ram_mode,
    input  logic              rx_req,
    input  logic [ADDR_W-1:0] rx_addr,
    input  logic [DATA_W-1:0] rx_wdata,
    output logic              rx_ack,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_ack,
    input  logic              tx_req,
    input  logic [ADDR_W-1:0] tx_addr,
    output logic              tx_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic              ram_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;
    typedef enum logic [1:0] {W_RX, W_P, W_TX} who_t;

    state_t            state, state_nx;
    who_t              who, win;
    logic              last_tx;
    logic              el_rx, el_p, el_tx, any_el, tie, blocked;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    always_comb begin
        el_rx   = rx_req && (mode == 2'b01);
        el_p    = p_req  && mode[1];
        el_tx   = tx_req && (mode == 2'b11);
        any_el  = el_rx || el_p || el_tx;
        tie     = el_p && el_tx;
        blocked = (rx_req && (mode != 2'b01)) || (p_req && !mode[1]) ||
                  (tx_req && (mode != 2'b11));
        win       = W_TX;
        win_we    = 1'b0;
        win_addr  = tx_addr;
        win_wdata = '0;
        if (el_rx) begin
            win       = W_RX;
            win_we    = 1'b1;
            win_addr  = rx_addr;
            win_wdata = rx_wdata;
        end else if (el_p && (!el_tx || last_tx)) begin
            win       = W_P;
            win_we    = p_we;
            win_addr  = p_addr;
            win_wdata = p_wdata;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_el) state_nx = ACCESS;
            ACCESS:  state_nx = ram_we ? DONE : CAPTURE;
            CAPTURE: state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    assign busy = (state != IDLE);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            who          <= W_RX;
            last_tx      <= 1'b0;
            ram_en       <= 1'b0;
            ram_we       <= 1'b0;
            ram_sel      <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            rdata        <= '0;
            rx_ack       <= 1'b0;
            p_ack        <= 1'b0;
            tx_ack       <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (blocked && (conflict_cnt != '1))
                        conflict_cnt <= conflict_cnt + CNT_W'(1);
                    if (any_el) begin
                        who       <= win;
                        ram_en    <= 1'b1;
                        ram_we    <= win_we;
                        ram_sel   <= ram_mode;
                        ram_addr  <= win_addr;
                        ram_wdata <= win_wdata;
                        // pointer only moves on a genuine tx/proc contest
                        if (tie) last_tx <= (win == W_TX);
                    end
                end
                ACCESS: begin
                    ram_en <= 1'b0;
                    ram_we <= 1'b0;
                    if (ram_we) begin
                        rx_ack <= (who == W_RX);
                        p_ack  <= (who == W_P);
                        tx_ack <= (who == W_TX);
                    end
                end
                CAPTURE: begin
                    rdata  <= ram_rdata;
                    rx_ack <= (who == W_RX);
                    p_ack  <= (who == W_P);
                    tx_ack <= (who == W_TX);
                end
                DONE: begin
                    rx_ack <= 1'b0;
                    p_ack  <= 1'b0;
                    tx_ack <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboarded bench for ram_access_arbiter with a registered falling-edge RAM model.
module tb_ram_access_arbiter;

    logic       clk = 1'b1;
    logic       reset;
    logic [1:0] mode;
    logic       ram_mode;
    logic       rx_req, p_req, p_we, tx_req;
    logic [7:0] rx_addr, rx_wdata, p_addr, p_wdata, tx_addr;
    logic       rx_ack, p_ack, tx_ack;
    logic [7:0] rdata, ram_addr, ram_wdata;
    logic       ram_en, ram_we, ram_sel, busy;
    logic [7:0] conflict_cnt;
    logic [7:0] ram_rdata = '0;

    always #5 clk = ~clk;

    ram_access_arbiter #(.ADDR_W(8), .DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .mode(mode), .ram_mode(ram_mode),
        .rx_req(rx_req), .rx_addr(rx_addr), .rx_wdata(rx_wdata), .rx_ack(rx_ack),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_ack(p_ack),
        .tx_req(tx_req), .tx_addr(tx_addr), .tx_ack(tx_ack),
        .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_sel(ram_sel),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .conflict_cnt(conflict_cnt)
    );

    // RAM model: unwritten words read back a fixed per-bank pattern
    logic [7:0]   mem [512];
    logic [511:0] wr_mask = '0;
    int           wr_cnt = 0;

    function automatic logic [7:0] pat(input logic [8:0] a);
        return a[8] ? (a[7:0] ^ 8'hD9) : (a[7:0] ^ 8'h7C);
    endfunction

    function automatic logic [7:0] ram_val(input logic [8:0] a);
        return wr_mask[a] ? mem[a] : pat(a);
    endfunction

    always @(negedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[{ram_sel, ram_addr}]     <= ram_wdata;
                wr_mask[{ram_sel, ram_addr}] <= 1'b1;
                wr_cnt                       <= wr_cnt + 1;
            end else begin
                ram_rdata <= ram_val({ram_sel, ram_addr});
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         who;   // 0 rx, 1 proc, 2 tx
        logic       rd;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    always @(posedge clk) begin
        if (rx_ack || p_ack || tx_ack) begin
            exp_t e;
            chk("ack_onehot", 32'(rx_ack) + 32'(p_ack) + 32'(tx_ack), 1);
            if (sb.size() == 0) begin
                chk("unexp_ack", {29'd0, rx_ack, p_ack, tx_ack}, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_who", tx_ack ? 2 : (p_ack ? 1 : 0), e.who);
                if (e.rd) chk("sb_rdata", rdata, e.data);
            end
        end
    end

    function automatic logic ack_of(input int w);
        return (w == 0) ? rx_ack : ((w == 1) ? p_ack : tx_ack);
    endfunction

    task automatic wait_ack(input int w, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!ack_of(w) && n < 20);
        if (!ack_of(w)) chk("ack_timeout", 0, 1);
    endtask

    task automatic push(input int w, input logic rd, input logic [7:0] d);
        exp_t e;
        e.who = w; e.rd = rd; e.data = d;
        sb.push_back(e);
    endtask

    int n, w0, stamp[4];

    initial begin
        reset = 0; mode = 0; ram_mode = 0;
        rx_req = 0; p_req = 0; p_we = 0; tx_req = 0;
        rx_addr = 0; rx_wdata = 0; p_addr = 0; p_wdata = 0; tx_addr = 0;
        repeat (2) @(posedge clk);
        chk("rst_outputs", {ram_en, ram_we, ram_sel, busy, rx_ack, p_ack, tx_ack, rdata, conflict_cnt}, 0);
        reset = 1;
        @(posedge clk);

        // reset asserted while a tx read sits in CAPTURE
        mode = 2'b11; ram_mode = 1; tx_addr = 8'h05; tx_req = 1;
        @(posedge clk);
        chk("t1_grant_en", {busy, ram_en, ram_sel, ram_addr}, {3'b111, 8'h05});
        @(posedge clk);
        chk("t1_access_done", {busy, ram_en}, 2'b10);
        reset = 0;
        #1;
        chk("t1_async_clear", {ram_en, ram_we, ram_sel, ram_addr, ram_wdata, rdata, busy,
                               rx_ack, p_ack, tx_ack, conflict_cnt}, 0);
        tx_req = 0; mode = 0;
        repeat (2) @(posedge clk);
        chk("t1_no_txack", tx_ack, 0);
        reset = 1;
        repeat (2) @(posedge clk);
        chk("t1_idle_after", {busy, conflict_cnt}, 0);

        // rx write in load mode
        mode = 2'b01; ram_mode = 0; rx_addr = 8'h12; rx_wdata = 8'hA5; w0 = wr_cnt;
        push(0, 0, 0);
        rx_req = 1;
        @(posedge clk);
        chk("t2_ram_cmd", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 8'h12, 8'hA5});
        rx_addr = 8'hEE; rx_wdata = 8'h00;
        wait_ack(0, n);
        chk("t2_ack_latency", n, 1);
        chk("t2_en_dropped", ram_en, 0);
        rx_req = 0;
        repeat (6) @(posedge clk);
        chk("t2_one_write", wr_cnt - w0, 1);
        chk("t2_mem", ram_val({1'b0, 8'h12}), 8'hA5);

        // proc read in process mode; ram_mode/addr changes after grant are ignored
        mode = 2'b10; ram_mode = 0; p_we = 0; p_addr = 8'h40;
        push(1, 1, 8'h3C);
        p_req = 1;
        @(posedge clk);
        ram_mode = 1; p_addr = 8'h41;
        wait_ack(1, n);
        chk("t3_ack_latency", n, 2);
        chk("t3_rdata", rdata, 8'h3C);
        chk("t3_sel_frozen", ram_sel, 0);
        p_req = 0;
        repeat (3) @(posedge clk);
        chk("t3_rdata_hold", rdata, 8'h3C);

        // transmit mode tie: alternation tx, p, tx, p at 4-cycle spacing
        mode = 2'b11; ram_mode = 1; tx_addr = 8'h50; p_addr = 8'h60; p_we = 0;
        for (int i = 0; i < 2; i++) begin
            push(2, 1, pat({1'b1, 8'h50}));
            push(1, 1, pat({1'b1, 8'h60}));
        end
        tx_req = 1; p_req = 1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin
                @(posedge clk);
                n++;
            end while (!(p_ack || tx_ack) && n < 20);
            if (!(p_ack || tx_ack)) chk("t4_ack_timeout", 0, 1);
            stamp[i] = n;
        end
        tx_req = 0; p_req = 0;
        for (int i = 1; i < 4; i++) chk("t4_spacing", stamp[i], 4);
        repeat (8) @(posedge clk);
        chk("t4_idle", busy, 0);

        // rx held in process mode: blocked, counter saturates
        mode = 2'b10; ram_mode = 0;
        chk("t5_cnt_start", conflict_cnt, 0);
        rx_req = 1; rx_addr = 8'h20; rx_wdata = 8'h55;
        repeat (10) @(posedge clk);
        chk("t5_cnt_10", conflict_cnt, 10);
        repeat (290) @(posedge clk);
        chk("t5_cnt_sat", conflict_cnt, 255);
        rx_req = 0;
        repeat (2) @(posedge clk);
        chk("t5_cnt_hold", {busy, conflict_cnt}, {1'b0, 8'd255});

        // mode drops to idle right after a proc write grant
        mode = 2'b10; ram_mode = 0; p_we = 1; p_addr = 8'h33; p_wdata = 8'h77; w0 = wr_cnt;
        push(1, 0, 0);
        p_req = 1;
        @(posedge clk);
        mode = 2'b00;
        wait_ack(1, n);
        chk("t6_ack_latency", n, 1);
        p_req = 0;
        repeat (2) @(posedge clk);
        chk("t6_mem", ram_val({1'b0, 8'h33}), 8'h77);
        p_req = 1;
        repeat (10) @(posedge clk);
        chk("t6_no_grant", {busy, 8'(wr_cnt - w0)}, {1'b0, 8'd1});
        p_req = 0;
        repeat (2) @(posedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
